// File: rtl/display_sequencer_pkg.sv
// Shared encodings for the output-select sequencer: mode/state codes, view codes
// and small helpers used by the sequencer and its debouncers.
package display_sequencer_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  // View codes seen by the output mux (also used by the mux bench).
  localparam logic [1:0] SEL_SWITCHES = 2'b00;
  localparam logic [1:0] SEL_INSTR    = 2'b01;
  localparam logic [1:0] SEL_INDEX    = 2'b10;
  localparam logic [1:0] SEL_STAT_ACC = 2'b11;

  localparam logic [1:0] DIG_LO = 2'b01;
  localparam logic [1:0] DIG_HI = 2'b10;

  // State values double as the MODE LED code, so MODE is just the state register.
  typedef enum logic [1:0] {
    ST_MANUAL = MODE_MANUAL,
    ST_RUN    = MODE_RUN,
    ST_HOLD   = MODE_HOLD
  } state_t;

  function automatic logic [1:0] next_view(input logic [1:0] v);
    return v + 2'd1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Board-side signal bundle of the display sequencer: switch/button inputs and
// mux select, mode LEDs and digit scan outputs.
interface display_sequencer_if;
  logic       SW18;
  logic       SW22;
  logic       AUTO;
  logic       PAUSE;
  logic       STEP;
  logic [1:0] SEL;
  logic [1:0] MODE;
  logic [1:0] DIGIT_EN;
  logic       DIGIT_SEL;

  modport master (
    output SW18, SW22, AUTO, PAUSE, STEP,
    input  SEL, MODE, DIGIT_EN, DIGIT_SEL
  );

  modport slave (
    input  SW18, SW22, AUTO, PAUSE, STEP,
    output SEL, MODE, DIGIT_EN, DIGIT_SEL
  );
endinterface

// File: rtl/display_sequencer_button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, run-length debounce and a
// one-cycle pulse on each debounced rising edge.
module button_debounce
  import display_sequencer_pkg::*;
#(
  parameter int DEB_CYC = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = cnt_w(DEB_CYC);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          rise_q;
  logic          raw_s;

  assign raw_s = sync_q[1];

  // Count consecutive disagreeing cycles; any agreement restarts the run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      rise_q <= 1'b0;
      if (raw_s == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYC - 1)) begin
        level_q <= raw_s;
        cnt_q   <= '0;
        rise_q  <= raw_s;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/display_sequencer.sv
// Output-select sequencer: manual/auto-run/hold view selection for the board's
// display mux plus the free-running two-digit 7-segment scan.
module display_sequencer
  import display_sequencer_pkg::*;
#(
  parameter int DEB_CYC   = 16,
  parameter int DWELL_CYC = 1000,
  parameter int SCAN_DIV  = 50
) (
  input  logic                 CLK,
  input  logic                 RST,
  display_sequencer_if.slave   bus
);

  localparam int DW = cnt_w(DWELL_CYC);
  localparam int SW = cnt_w(SCAN_DIV);

  logic [1:0]    sw18_q, sw22_q, auto_q;
  logic          sw18_s, sw22_s, auto_s;
  logic          pause_p, step_p;
  state_t        state_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] dwell_q;
  logic [SW-1:0] scan_q;
  logic [1:0]    de_q, de_d;
  logic          dsel_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw18_q <= '0;
      sw22_q <= '0;
      auto_q <= '0;
    end else begin
      sw18_q <= {sw18_q[0], bus.SW18};
      sw22_q <= {sw22_q[0], bus.SW22};
      auto_q <= {auto_q[0], bus.AUTO};
    end
  end

  assign sw18_s = sw18_q[1];
  assign sw22_s = sw22_q[1];
  assign auto_s = auto_q[1];

  button_debounce #(.DEB_CYC(DEB_CYC)) u_pause (
    .CLK     (CLK),
    .RST     (RST),
    .raw_i   (bus.PAUSE),
    .level_o (),
    .rise_o  (pause_p)
  );

  button_debounce #(.DEB_CYC(DEB_CYC)) u_step (
    .CLK     (CLK),
    .RST     (RST),
    .raw_i   (bus.STEP),
    .level_o (),
    .rise_o  (step_p)
  );

  // AUTO low wins over everything and snaps SEL back onto the switches at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_MANUAL;
      sel_q   <= SEL_SWITCHES;
      dwell_q <= '0;
    end else if (!auto_s) begin
      state_q <= ST_MANUAL;
      sel_q   <= {sw18_s, sw22_s};
      dwell_q <= '0;
    end else begin
      case (state_q)
        ST_MANUAL: begin
          state_q <= ST_RUN;
          dwell_q <= '0;
        end
        ST_RUN: begin
          if (pause_p) begin
            state_q <= ST_HOLD;
          end else if (dwell_q == DW'(DWELL_CYC - 1)) begin
            sel_q   <= next_view(sel_q);
            dwell_q <= '0;
          end else begin
            dwell_q <= dwell_q + DW'(1);
          end
        end
        ST_HOLD: begin
          if (pause_p) begin
            state_q <= ST_RUN;
            dwell_q <= '0;
          end else if (step_p) begin
            sel_q <= next_view(sel_q);
          end
        end
        default: begin
          state_q <= ST_MANUAL;
          dwell_q <= '0;
        end
      endcase
    end
  end

  // Rotating the one-hot pair keeps DIGIT_EN strictly 01/10.
  assign de_d = {de_q[0], de_q[1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_q <= '0;
      de_q   <= DIG_LO;
      dsel_q <= 1'b0;
    end else if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_q <= '0;
      de_q   <= de_d;
      dsel_q <= de_d[1];
    end else begin
      scan_q <= scan_q + SW'(1);
    end
  end

  assign bus.SEL       = sel_q;
  assign bus.MODE      = state_q;
  assign bus.DIGIT_EN  = de_q;
  assign bus.DIGIT_SEL = dsel_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized bench for display_sequencer with a behavioural reference model
// plus directed scenarios pinned by hand-computed literal expectations.
module tb_display_sequencer;
  import display_sequencer_pkg::*;

  localparam int DEB   = 4;
  localparam int DWELL = 8;
  localparam int SCAN  = 3;

  logic CLK = 1'b0;
  logic RST;
  display_sequencer_if bus ();

  display_sequencer #(.DEB_CYC(DEB), .DWELL_CYC(DWELL), .SCAN_DIV(SCAN)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int npass = 0;
  int ntot  = 0;
  bit cmp_en = 1'b0;

  // Reference model: inputs become visible two edges after being sampled, a
  // button level flips once the last DEB visible samples all disagree with it,
  // and views advance once per DWELL cycles spent in RUN.
  logic [4:0] dly[$];
  bit         win_p[$], win_s[$];
  bit         lvl_p, lvl_s, pul_p, pul_s;
  int         m_edges, m_dwell;
  logic [1:0] m_sel, m_mode;

  function automatic bit all_is(input bit q[$], input bit v);
    if (q.size() != DEB) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge CLK) begin
    logic [4:0] s;
    if (RST) begin
      dly = '{5'd0, 5'd0};
      win_p.delete();
      win_s.delete();
      lvl_p = 0; lvl_s = 0; pul_p = 0; pul_s = 0;
      m_edges = 0; m_dwell = 0;
      m_sel = SEL_SWITCHES; m_mode = MODE_MANUAL;
    end else begin
      s = dly.pop_front();
      dly.push_back({bus.STEP, bus.PAUSE, bus.AUTO, bus.SW22, bus.SW18});
      m_edges++;
      if (!s[2]) begin
        m_mode = MODE_MANUAL;
        m_sel  = {s[0], s[1]};
      end else if (m_mode == MODE_MANUAL) begin
        m_mode = MODE_RUN; m_dwell = 0;
      end else if (m_mode == MODE_RUN) begin
        if (pul_p) m_mode = MODE_HOLD;
        else begin
          m_dwell++;
          if (m_dwell == DWELL) begin m_sel = m_sel + 2'd1; m_dwell = 0; end
        end
      end else begin
        if (pul_p) begin m_mode = MODE_RUN; m_dwell = 0; end
        else if (pul_s) m_sel = m_sel + 2'd1;
      end
      win_p.push_back(s[3]);
      if (win_p.size() > DEB) void'(win_p.pop_front());
      win_s.push_back(s[4]);
      if (win_s.size() > DEB) void'(win_s.pop_front());
      pul_p = 0; pul_s = 0;
      if (all_is(win_p, !lvl_p)) begin lvl_p = !lvl_p; pul_p = lvl_p; end
      if (all_is(win_s, !lvl_s)) begin lvl_s = !lvl_s; pul_s = lvl_s; end
    end
  end

  function automatic logic [1:0] exp_de();
    return ((m_edges / SCAN) % 2 == 1) ? DIG_HI : DIG_LO;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic cyc();
    logic [1:0] de;
    @(negedge CLK);
    if (cmp_en) begin
      de = exp_de();
      chk("model_SEL", bus.SEL, m_sel);
      chk("model_MODE", bus.MODE, m_mode);
      chk("model_DIGIT_EN", bus.DIGIT_EN, de);
      chk("model_DIGIT_SEL", bus.DIGIT_SEL, de[1]);
    end
  endtask

  task automatic wait_mode(input logic [1:0] m, input int lim, output int n);
    n = 0;
    while (bus.MODE !== m && n < lim) begin cyc(); n++; end
  endtask

  task automatic cycles_to_change(input int lim, output int n);
    logic [1:0] s0;
    s0 = bus.SEL;
    n = 0;
    do begin cyc(); n++; end while (bus.SEL === s0 && n < lim);
  endtask

  task automatic press_step();
    bus.STEP = 1'b1; repeat (6) cyc();
    bus.STEP = 1'b0; repeat (8) cyc();
  endtask

  initial begin
    logic [1:0] de_tab [7];
    logic [1:0] sel_tab [3];
    logic [1:0] frozen;
    int n;
    de_tab  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    sel_tab = '{2'b11, 2'b00, 2'b01};
    RST = 1'b1;
    bus.SW18 = 0; bus.SW22 = 0; bus.AUTO = 0; bus.PAUSE = 0; bus.STEP = 0;
    repeat (3) cyc();
    cmp_en = 1'b1;
    RST = 1'b0;

    // 1: manual select latency and scan pattern from reset
    chk("reset_SEL", bus.SEL, 2'b00);
    chk("reset_DIGIT_SEL", bus.DIGIT_SEL, 1'b0);
    bus.SW18 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("scan_pattern", bus.DIGIT_EN, de_tab[i]);
      if (i == 2) chk("sel_before_latency", bus.SEL, 2'b00);
      if (i == 3) chk("sel_after_3_cycles", bus.SEL, 2'b10);
      cyc();
    end
    chk("manual_MODE", bus.MODE, MODE_MANUAL);

    // 2: auto-run dwell and wrap
    bus.AUTO = 1'b1;
    wait_mode(MODE_RUN, 10, n);
    chk("auto_latency", n, 3);
    chk("run_keeps_SEL", bus.SEL, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cycles_to_change(20, n);
      chk("dwell_cycles", n, DWELL);
      chk("run_SEL", bus.SEL, sel_tab[i]);
    end

    // 3: bounced pause ignored, clean pause holds
    bus.PAUSE = 1'b1; repeat (3) cyc();
    bus.PAUSE = 1'b0; repeat (10) cyc();
    chk("bounce_no_hold", bus.MODE, MODE_RUN);
    bus.PAUSE = 1'b1; repeat (6) cyc();
    bus.PAUSE = 1'b0; repeat (4) cyc();
    chk("pause_to_hold", bus.MODE, MODE_HOLD);
    frozen = m_sel;
    repeat (60) cyc();
    chk("hold_frozen_SEL", bus.SEL, frozen);
    chk("hold_MODE", bus.MODE, MODE_HOLD);

    // 4: single steps and held step
    for (int i = 0; i < 4 && bus.SEL !== 2'b11; i++) press_step();
    chk("step_reach_11", bus.SEL, 2'b11);
    press_step();
    chk("step_wrap_00", bus.SEL, 2'b00);
    press_step();
    chk("step_01", bus.SEL, 2'b01);
    bus.STEP = 1'b1; repeat (40) cyc();
    chk("held_step_once", bus.SEL, 2'b10);
    bus.STEP = 1'b0; repeat (8) cyc();
    chk("step_release_no_adv", bus.SEL, 2'b10);

    // 5: pause and step together
    bus.PAUSE = 1'b1; bus.STEP = 1'b1; repeat (6) cyc();
    bus.PAUSE = 1'b0; bus.STEP = 1'b0;
    wait_mode(MODE_RUN, 10, n);
    chk("both_to_run", bus.MODE, MODE_RUN);
    chk("both_no_adv", bus.SEL, 2'b10);
    cycles_to_change(20, n);
    chk("resume_dwell", n, DWELL);
    chk("resume_SEL", bus.SEL, 2'b11);

    // 6: reset mid-dwell with AUTO still high
    repeat (3) cyc();
    RST = 1'b1; cyc();
    chk("rst_SEL", bus.SEL, 2'b00);
    chk("rst_MODE", bus.MODE, MODE_MANUAL);
    chk("rst_DIGIT_EN", bus.DIGIT_EN, 2'b01);
    chk("rst_DIGIT_SEL", bus.DIGIT_SEL, 1'b0);
    RST = 1'b0;
    repeat (2) cyc();
    chk("rst_sync_wait", bus.MODE, MODE_MANUAL);
    cyc();
    chk("rst_back_to_run", bus.MODE, MODE_RUN);

    // Random phase: bouncy buttons, switch/AUTO flips and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.PAUSE = ~bus.PAUSE;
      if ($urandom_range(0, 6) == 0) bus.STEP = ~bus.STEP;
      if ($urandom_range(0, 59) == 0) bus.SW18 = ~bus.SW18;
      if ($urandom_range(0, 59) == 0) bus.SW22 = ~bus.SW22;
      if ($urandom_range(0, 199) == 0) bus.AUTO = ~bus.AUTO;
      RST = ($urandom_range(0, 499) == 0);
      cyc();
    end
    RST = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
